// File: rtl/gmii_if.sv
// GMII transmit bundle: one byte per clock with a frame-valid strobe and an
// error strobe. The framer drives the master side.
interface gmii_if;
  logic [7:0] data;
  logic       valid;
  logic       error;

  modport master (output data, output valid, output error);
  modport slave  (input  data, input  valid, input  error);
endinterface

// File: rtl/gmii_tx_framer.sv
// Transmit framer: wraps a payload stream in preamble, SFD, zero pad and
// CRC-32 FCS on a registered GMII output, then holds the inter-packet gap.
module gmii_tx_framer #(
  parameter int PREAMBLE_BYTES    = 7,
  parameter int MIN_PAYLOAD_BYTES = 60,
  parameter int IFG_BYTES         = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  output logic       s_ready,
  gmii_if.master     gmii_if_tx_o,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PREAMBLE = 3'd1,
    SFD      = 3'd2,
    DATA     = 3'd3,
    PAD      = 3'd4,
    FCS      = 3'd5,
    DRAIN    = 3'd6,
    IFG      = 3'd7
  } state_t;

  localparam logic [15:0] PRE_C = 16'(PREAMBLE_BYTES);
  localparam logic [15:0] MIN_C = 16'(MIN_PAYLOAD_BYTES);
  localparam logic [15:0] IFG_C = 16'(IFG_BYTES);

  state_t      state, state_nxt;
  logic [15:0] cnt, cnt_nxt, cnt_inc;
  logic [31:0] crc, crc_nxt;
  logic [7:0]  tx_data_nxt;
  logic        tx_valid_nxt, tx_error_nxt;

  function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h000000, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction

  // Handshake: a byte moves when s_valid && s_ready; s_ready depends on state only.
  assign s_ready   = (state == DATA) || (state == DRAIN);
  assign state_dbg = state;
  assign cnt_inc   = cnt + 16'd1;

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    crc_nxt      = crc;
    tx_data_nxt  = 8'h00;
    tx_valid_nxt = 1'b0;
    tx_error_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (s_valid) begin
          tx_data_nxt  = 8'h55;
          tx_valid_nxt = 1'b1;
          cnt_nxt      = 16'd1;
          state_nxt    = (PRE_C <= 16'd1) ? SFD : PREAMBLE;
        end
      end
      PREAMBLE: begin
        tx_data_nxt  = 8'h55;
        tx_valid_nxt = 1'b1;
        cnt_nxt      = cnt_inc;
        if (cnt_inc >= PRE_C) state_nxt = SFD;
      end
      SFD: begin
        tx_data_nxt  = 8'hD5;
        tx_valid_nxt = 1'b1;
        crc_nxt      = 32'hFFFFFFFF;
        cnt_nxt      = 16'd0;
        state_nxt    = DATA;
      end
      DATA: begin
        tx_valid_nxt = 1'b1;
        if (s_valid) begin
          tx_data_nxt = s_data;
          crc_nxt     = crc32_byte(crc, s_data);
          cnt_nxt     = (cnt < MIN_C) ? cnt_inc : cnt;
          if (s_last) begin
            if (cnt_inc < MIN_C) begin
              state_nxt = PAD;
            end else begin
              state_nxt = FCS;
              cnt_nxt   = 16'd0;
            end
          end
        end else begin
          // Underrun: flag the frame as bad on the wire, then swallow the rest.
          tx_error_nxt = 1'b1;
          state_nxt    = DRAIN;
        end
      end
      PAD: begin
        tx_valid_nxt = 1'b1;
        crc_nxt      = crc32_byte(crc, 8'h00);
        if (cnt_inc >= MIN_C) begin
          state_nxt = FCS;
          cnt_nxt   = 16'd0;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      FCS: begin
        tx_valid_nxt = 1'b1;
        case (cnt[1:0])
          2'd0:    tx_data_nxt = ~crc[7:0];
          2'd1:    tx_data_nxt = ~crc[15:8];
          2'd2:    tx_data_nxt = ~crc[23:16];
          default: tx_data_nxt = ~crc[31:24];
        endcase
        cnt_nxt = cnt_inc;
        if (cnt[1:0] == 2'd3) begin
          state_nxt = IFG;
          cnt_nxt   = 16'd0;
        end
      end
      DRAIN: begin
        if (s_valid && s_last) begin
          state_nxt = IFG;
          cnt_nxt   = 16'd0;
        end
      end
      IFG: begin
        // The first IFG cycle still shows the final FCS byte on the wire, so
        // the state lasts one cycle longer than the idle gap it guarantees.
        if (cnt >= IFG_C) begin
          state_nxt = IDLE;
          cnt_nxt   = 16'd0;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= IDLE;
      cnt                <= 16'd0;
      crc                <= 32'hFFFFFFFF;
      gmii_if_tx_o.data  <= 8'h00;
      gmii_if_tx_o.valid <= 1'b0;
      gmii_if_tx_o.error <= 1'b0;
    end else begin
      state              <= state_nxt;
      cnt                <= cnt_nxt;
      crc                <= crc_nxt;
      gmii_if_tx_o.data  <= tx_data_nxt;
      gmii_if_tx_o.valid <= tx_valid_nxt;
      gmii_if_tx_o.error <= tx_error_nxt;
    end
  end

endmodule

// File: tb/tb_gmii_tx_framer.sv
// Bench for gmii_tx_framer: a default-parameter instance and an unpadded
// instance, each checked byte-for-byte against an expected-output queue.
module tb_gmii_tx_framer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] s_data = 8'h00, s_data_np = 8'h00;
  logic       s_valid = 1'b0, s_valid_np = 1'b0;
  logic       s_last = 1'b0, s_last_np = 1'b0;
  logic       s_ready, s_ready_np;
  logic [2:0] state_dbg, state_dbg_np;
  gmii_if g();
  gmii_if g_np();

  gmii_tx_framer u_dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready), .gmii_if_tx_o(g), .state_dbg(state_dbg)
  );

  gmii_tx_framer #(.MIN_PAYLOAD_BYTES(0)) u_dut_np (
    .clk(clk), .rst(rst), .s_data(s_data_np), .s_valid(s_valid_np), .s_last(s_last_np),
    .s_ready(s_ready_np), .gmii_if_tx_o(g_np), .state_dbg(state_dbg_np)
  );

  logic [8:0] exp_q[$];
  logic [8:0] exp_np_q[$];
  logic [7:0] st_data[$];
  bit         st_last[$];
  int         st_gap[$];
  int n_cmp = 0, n_fail = 0;
  int pres_cyc, acc_cyc;

  typedef struct {
    int         len;
    logic [7:0] b0;
    int         step;
    int         exp_valid;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag_fail(input string name, input logic [31:0] act);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: got 0x%0h, expected nothing (cycle %0d)", name, act, cyc);
  endtask

  // Monitor: default instance
  int  vcnt = 0, last_rise = 0, last_gap = 0, gap_run = 0;
  bit  prev_v = 1'b0, chk_ifg_ready = 1'b0;
  always @(negedge clk) begin
    if (g.valid === 1'b1) begin
      if (!prev_v) begin
        last_rise = cyc;
        last_gap  = gap_run;
      end
      gap_run = 0;
      prev_v  = 1'b1;
      vcnt++;
      if (exp_q.size() == 0) flag_fail("unexpected_byte", {23'd0, g.error, g.data});
      else chk("gmii_byte", {23'd0, g.error, g.data}, {23'd0, exp_q.pop_front()});
    end else begin
      prev_v = 1'b0;
      gap_run++;
      chk("idle_error", {31'd0, g.error}, 32'd0);
      if (chk_ifg_ready) chk("ifg_s_ready", {31'd0, s_ready}, 32'd0);
    end
  end

  // Monitor: unpadded instance
  int vcnt_np = 0, first_np = 0, d5_np = 0, last_np = 0;
  always @(negedge clk) begin
    if (g_np.valid === 1'b1) begin
      vcnt_np++;
      if (vcnt_np == 1) first_np = cyc;
      if (vcnt_np == 8) d5_np = cyc;
      last_np = cyc;
      if (exp_np_q.size() == 0) flag_fail("np_unexpected_byte", {23'd0, g_np.error, g_np.data});
      else chk("np_gmii_byte", {23'd0, g_np.error, g_np.data}, {23'd0, exp_np_q.pop_front()});
    end
  end

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    logic        fb;
    r = c;
    for (int i = 0; i < 8; i++) begin
      fb = r[0] ^ b[i];
      r  = {1'b0, r[31:1]};
      if (fb) r = r ^ 32'hEDB88320;
    end
    return r;
  endfunction

  task automatic push_exp(input bit np, input logic [8:0] v);
    if (np) exp_np_q.push_back(v);
    else exp_q.push_back(v);
  endtask

  task automatic clear_stream();
    st_data.delete();
    st_last.delete();
    st_gap.delete();
  endtask

  // Queue a frame for the driver and its expected wire bytes for the monitor.
  task automatic build_frame(input int len, input logic [7:0] b0, input int step, input bit np);
    logic [7:0]  b;
    logic [31:0] c;
    int          total;
    total = (!np && len < 60) ? 60 : len;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < 7; i++) push_exp(np, 9'h055);
    push_exp(np, 9'h0D5);
    for (int i = 0; i < total; i++) begin
      b = (i < len) ? 8'(int'(b0) + i * step) : 8'h00;
      if (i < len) begin
        st_data.push_back(b);
        st_last.push_back(i == len - 1);
        st_gap.push_back(0);
      end
      c = crc_step(c, b);
      push_exp(np, {1'b0, b});
    end
    c = ~c;
    for (int k = 0; k < 4; k++) push_exp(np, {1'b0, c[8*k +: 8]});
  endtask

  task automatic set_in(input bit np, input bit v, input logic [7:0] d, input bit l);
    if (np) begin
      s_valid_np = v; s_data_np = d; s_last_np = l;
    end else begin
      s_valid = v; s_data = d; s_last = l;
    end
  endtask

  // Stream st_* entries; rst_at >= 0 pulses reset while that entry is presented.
  task automatic drive(input bit np, input int rst_at);
    bit fire;
    int t;
    for (int i = 0; i < st_data.size(); i++) begin
      if (st_gap[i] > 0) begin
        set_in(np, 1'b0, 8'h00, 1'b0);
        repeat (st_gap[i]) @(posedge clk);
        #1;
      end
      set_in(np, 1'b1, st_data[i], st_last[i]);
      if (i == 0) pres_cyc = cyc;
      if (i == rst_at) begin
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        set_in(np, 1'b0, 8'h00, 1'b0);
        return;
      end
      fire = 1'b0;
      t    = 0;
      while (!fire && t < 3000) begin
        @(negedge clk);
        fire = np ? s_ready_np : s_ready;
        @(posedge clk);
        #1;
        t++;
      end
      if (!fire) begin
        flag_fail("accept_timeout", 32'(i));
        set_in(np, 1'b0, 8'h00, 1'b0);
        return;
      end
      acc_cyc = cyc - 1;
    end
    set_in(np, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic wait_drain(input bit np, input int extra);
    int t;
    t = 0;
    while ((np ? exp_np_q.size() : exp_q.size()) != 0 && t < 5000) begin
      @(posedge clk);
      t++;
    end
    #1;
    if (t >= 5000) flag_fail("drain_timeout", 32'(np ? exp_np_q.size() : exp_q.size()));
    repeat (extra) @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a;
    tbl[0] = '{len: 1,   b0: 8'hAB, step: 0, exp_valid: 72};
    tbl[1] = '{len: 2,   b0: 8'h10, step: 3, exp_valid: 72};
    tbl[2] = '{len: 59,  b0: 8'h01, step: 1, exp_valid: 72};
    tbl[3] = '{len: 60,  b0: 8'h80, step: 7, exp_valid: 72};
    tbl[4] = '{len: 61,  b0: 8'hFF, step: 1, exp_valid: 73};
    tbl[5] = '{len: 100, b0: 8'h00, step: 5, exp_valid: 112};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", {31'd0, g.valid}, 32'd0);
    chk("rst_error", {31'd0, g.error}, 32'd0);
    chk("rst_data", {24'd0, g.data}, 32'd0);
    chk("rst_s_ready", {31'd0, s_ready}, 32'd0);
    chk("rst_state", {29'd0, state_dbg}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Idle with s_valid low
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("idle_out", {21'd0, g.valid, g.error, g.data, s_ready}, 32'd0);
      chk("idle_out_np", {21'd0, g_np.valid, g_np.error, g_np.data, s_ready_np}, 32'd0);
    end
    @(posedge clk);
    #1;

    // Unpadded "123456789": known check value 0xCBF43926
    clear_stream();
    for (int i = 0; i < 7; i++) exp_np_q.push_back(9'h055);
    exp_np_q.push_back(9'h0D5);
    for (int i = 0; i < 9; i++) begin
      st_data.push_back(8'(8'h31 + i));
      st_last.push_back(i == 8);
      st_gap.push_back(0);
      exp_np_q.push_back({1'b0, 8'(8'h31 + i)});
    end
    exp_np_q.push_back(9'h026);
    exp_np_q.push_back(9'h039);
    exp_np_q.push_back(9'h0F4);
    exp_np_q.push_back(9'h0CB);
    drive(1'b1, -1);
    wait_drain(1'b1, 14);
    chk("np_valid_count", 32'(vcnt_np), 32'd21);
    chk("np_first_preamble", 32'(first_np - pres_cyc), 32'd1);
    chk("np_sfd_cycle", 32'(d5_np - pres_cyc), 32'd8);
    chk("np_last_fcs", 32'(last_np - pres_cyc), 32'd21);

    // Table of single frames on the padded instance
    for (int v = 0; v < 6; v++) begin
      clear_stream();
      vcnt = 0;
      build_frame(tbl[v].len, tbl[v].b0, tbl[v].step, 1'b0);
      drive(1'b0, -1);
      wait_drain(1'b0, 16);
      chk($sformatf("tbl%0d_valid_count", v), 32'(vcnt), 32'(tbl[v].exp_valid));
    end

    // Underrun after 20 bytes, s_last later while draining
    clear_stream();
    vcnt = 0;
    for (int i = 0; i < 7; i++) exp_q.push_back(9'h055);
    exp_q.push_back(9'h0D5);
    for (int i = 0; i < 20; i++) begin
      st_data.push_back(8'(8'h40 + i));
      st_last.push_back(1'b0);
      st_gap.push_back(0);
      exp_q.push_back({1'b0, 8'(8'h40 + i)});
    end
    exp_q.push_back(9'h100);
    st_data.push_back(8'h77);
    st_last.push_back(1'b1);
    st_gap.push_back(4);
    drive(1'b0, -1);
    a = acc_cyc;
    wait_drain(1'b0, 2);
    chk("underrun_valid_count", 32'(vcnt), 32'd29);
    clear_stream();
    build_frame(64, 8'h22, 1, 1'b0);
    drive(1'b0, -1);
    wait_drain(1'b0, 16);
    chk("underrun_gap_ok", {31'd0, (last_rise - a) >= 13}, 32'd1);

    // Back-to-back 64-byte frames with s_valid held high
    clear_stream();
    build_frame(64, 8'h01, 3, 1'b0);
    build_frame(64, 8'h90, 1, 1'b0);
    chk_ifg_ready = 1'b1;
    drive(1'b0, -1);
    wait_drain(1'b0, 16);
    chk_ifg_ready = 1'b0;
    chk("b2b_gap", 32'(last_gap), 32'd13);

    // Reset pulse while byte 30 is presented, then a clean frame
    clear_stream();
    build_frame(60, 8'h5A, 1, 1'b0);
    while (exp_q.size() > 38) void'(exp_q.pop_back());
    drive(1'b0, 30);
    @(negedge clk);
    chk("rst_midframe_valid", {31'd0, g.valid}, 32'd0);
    chk("rst_midframe_flush", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
    clear_stream();
    vcnt = 0;
    build_frame(40, 8'hC3, 11, 1'b0);
    drive(1'b0, -1);
    wait_drain(1'b0, 16);
    chk("post_rst_valid_count", 32'(vcnt), 32'd72);

    chk("final_queue", 32'(exp_q.size()), 32'd0);
    chk("final_queue_np", 32'(exp_np_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
